sector_flush_scheduler: RTL and testbench

- Write-back controller for the dirty-sector bitmap: on a flush command, walks the dirty bits in round-robin order and hands each dirty sector to the storage writer over a req/ack/done handshake.
- Clears each bit once its write completes.
- Owns the single set/clear port of the bitmap, merging host "mark dirty" writes with its own clears.
- Sits between the host write path, the dirty-sector bitmap and the storage writer.

---
 rtl/sector_flush_scheduler_pkg.sv | 23 ++
 rtl/sector_flush_scheduler_if.sv | 40 ++++
 rtl/sector_flush_scheduler_rr_sector_picker.sv | 31 +++
 rtl/sector_flush_scheduler.sv | 135 +++++++++++++
 tb/tb_sector_flush_scheduler.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sector_flush_scheduler_pkg.sv
// Shared types and constants for the dirty-sector flush path.
// Sector count, sector address type and the flush FSM state encoding.
package sector_flush_scheduler_pkg;

  localparam int NSECT   = 64;
  localparam int SADDR_W = $clog2(NSECT);

  typedef logic [SADDR_W-1:0] saddr_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PICK  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_CLEAR = 3'd4
  } flush_state_t;

  // Round-robin successor; wraps NSECT-1 back to sector 0.
  function automatic saddr_t next_saddr(input saddr_t a);
    return (int'(a) == NSECT - 1) ? '0 : a + SADDR_W'(1);
  endfunction

endpackage

// File: rtl/sector_flush_scheduler_if.sv
// Bundle of host, bitmap-port and storage-writer signals around the scheduler.
// master = scheduler side, slave = environment (host, bitmap, writer).
interface sector_flush_scheduler_if;
  import sector_flush_scheduler_pkg::*;

  logic [NSECT-1:0] dirty_sectors;
  logic             all_clean;
  logic             host_set;
  saddr_t           host_saddr;
  logic             flush_start;
  logic             ds_en;
  saddr_t           ds_saddr;
  logic             ds_d;
  // wr_req is held with wr_saddr stable until the cycle wr_ack is seen high;
  // the transfer happens on that edge. wr_done (qualified by wr_err) closes it.
  logic             wr_req;
  saddr_t           wr_saddr;
  logic             wr_ack;
  logic             wr_done;
  logic             wr_err;
  logic             busy;
  logic             flush_done;
  logic             flush_error;
  flush_state_t     dbg_state;

  modport master (
    input  dirty_sectors, all_clean, host_set, host_saddr, flush_start,
           wr_ack, wr_done, wr_err,
    output ds_en, ds_saddr, ds_d, wr_req, wr_saddr, busy, flush_done,
           flush_error, dbg_state
  );

  modport slave (
    output dirty_sectors, all_clean, host_set, host_saddr, flush_start,
           wr_ack, wr_done, wr_err,
    input  ds_en, ds_saddr, ds_d, wr_req, wr_saddr, busy, flush_done,
           flush_error, dbg_state
  );

endinterface

// File: rtl/sector_flush_scheduler_rr_sector_picker.sv
// Rotating priority encoder: first set bit at or after i_start, wrapping.
// Purely combinational so it can serve any bitmap scan.
module rr_sector_picker
  import sector_flush_scheduler_pkg::*;
#(
  parameter int N = NSECT,
  parameter int W = SADDR_W
) (
  input  logic [N-1:0] i_bitmap,
  input  logic [W-1:0] i_start,
  output logic         o_found,
  output logic [W-1:0] o_idx
);

  logic [W-1:0] w_k;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_k     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_k = W'((int'(i_start) + i) % N);
      if (i_bitmap[w_k]) begin
        o_found = 1'b1;
        o_idx   = w_k;
      end
    end
  end

endmodule

// File: rtl/sector_flush_scheduler.sv
// Write-back controller: walks dirty sectors round-robin, hands each to the
// storage writer, and clears its bitmap bit through the shared set/clear port.
module sector_flush_scheduler
  import sector_flush_scheduler_pkg::*;
#(
  parameter int MAX_RETRY = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  sector_flush_scheduler_if.master   bus
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  flush_state_t  r_state;
  flush_state_t  w_next_state;
  saddr_t        r_ptr;
  saddr_t        r_wr_saddr;
  logic [RW-1:0] r_retry;
  logic          r_redirty;
  logic          r_flush_done;
  logic          r_flush_error;

  logic          w_found;
  saddr_t        w_idx;
  logic          w_pick_ok;
  logic          w_done_seen;
  logic          w_can_retry;
  logic          w_host_hit;
  logic          w_clear_exit;

  rr_sector_picker #(.N(NSECT), .W(SADDR_W)) u_picker (
    .i_bitmap (bus.dirty_sectors),
    .i_start  (r_ptr),
    .o_found  (w_found),
    .o_idx    (w_idx)
  );

  assign w_pick_ok   = w_found && !bus.all_clean;
  // A done coinciding with the ack is handled as if it arrived in WAIT.
  assign w_done_seen = bus.wr_done &&
                       ((r_state == ST_WAIT) || (r_state == ST_ISSUE && bus.wr_ack));
  assign w_can_retry = (r_retry < RETRY_LIMIT);
  assign w_host_hit  = bus.host_set && (bus.host_saddr == r_wr_saddr);
  assign w_clear_exit = (r_state == ST_CLEAR) && (r_redirty || !bus.host_set);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:  if (bus.flush_start) w_next_state = ST_PICK;
      ST_PICK:  w_next_state = w_pick_ok ? ST_ISSUE : ST_IDLE;
      ST_ISSUE, ST_WAIT: begin
        if (w_done_seen) begin
          if (!bus.wr_err)      w_next_state = ST_CLEAR;
          else if (w_can_retry) w_next_state = ST_ISSUE;
          else                  w_next_state = ST_IDLE;
        end else if (r_state == ST_ISSUE && bus.wr_ack) begin
          w_next_state = ST_WAIT;
        end
      end
      ST_CLEAR: if (w_clear_exit) w_next_state = ST_PICK;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr         <= '0;
      r_wr_saddr    <= '0;
      r_retry       <= '0;
      r_redirty     <= 1'b0;
      r_flush_done  <= 1'b0;
      r_flush_error <= 1'b0;
    end else begin
      r_flush_done  <= (r_state == ST_PICK) && !w_pick_ok;
      r_flush_error <= w_done_seen && bus.wr_err && !w_can_retry;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.flush_start) begin
            r_retry   <= '0;
            r_redirty <= 1'b0;
          end
        end
        ST_PICK: begin
          if (w_pick_ok) begin
            r_wr_saddr <= w_idx;
            r_redirty  <= 1'b0;
          end
        end
        ST_ISSUE, ST_WAIT: begin
          // Host rewrote the sector in flight: the data being written is stale.
          if (w_host_hit) r_redirty <= 1'b1;
          if (w_done_seen && bus.wr_err && w_can_retry) r_retry <= r_retry + RW'(1);
        end
        ST_CLEAR: begin
          if (w_host_hit) r_redirty <= 1'b1;
          if (w_clear_exit) begin
            r_ptr   <= next_saddr(r_wr_saddr);
            r_retry <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Host writes always own the bitmap port; the scheduler clears only when it is free.
  always_comb begin
    bus.ds_en       = 1'b0;
    bus.ds_saddr    = '0;
    bus.ds_d        = 1'b0;
    if (bus.host_set) begin
      bus.ds_en    = 1'b1;
      bus.ds_saddr = bus.host_saddr;
      bus.ds_d     = 1'b1;
    end else if (r_state == ST_CLEAR && !r_redirty) begin
      bus.ds_en    = 1'b1;
      bus.ds_saddr = r_wr_saddr;
      bus.ds_d     = 1'b0;
    end
    bus.wr_req      = (r_state == ST_ISSUE);
    bus.wr_saddr    = r_wr_saddr;
    bus.busy        = (r_state != ST_IDLE);
    bus.flush_done  = r_flush_done;
    bus.flush_error = r_flush_error;
    bus.dbg_state   = r_state;
  end

endmodule

// File: tb/tb_sector_flush_scheduler.sv
// Bench for sector_flush_scheduler: per-cycle vector table for ordering and
// port-mux behaviour, then modelled-bitmap sequences for wrap, redirty, retries, reset.
module tb_sector_flush_scheduler;
  import sector_flush_scheduler_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sector_flush_scheduler_if bus ();

  sector_flush_scheduler #(.MAX_RETRY(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        fs, hs;
    int          ha;
    logic        ack, done, err;
    logic [63:0] dirty;
    logic        req;
    int          wsa;
    logic        den;
    int          dsa;
    logic        dd, busy, fdone, ferr;
  } vec_t;

  vec_t vecs[$];

  logic [SADDR_W-1:0] exp_q[$];
  logic [SADDR_W-1:0] got_q[$];
  logic [63:0]        bm;
  logic               busy_at_end;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic fs, input logic hs, input int ha,
                              input logic ack, input logic done, input logic err,
                              input logic [63:0] dirty, input logic req, input int wsa,
                              input logic den, input int dsa, input logic dd,
                              input logic busy, input logic fdone, input logic ferr);
    vec_t v;
    v.fs = fs; v.hs = hs; v.ha = ha; v.ack = ack; v.done = done; v.err = err;
    v.dirty = dirty; v.req = req; v.wsa = wsa; v.den = den; v.dsa = dsa;
    v.dd = dd; v.busy = busy; v.fdone = fdone; v.ferr = ferr;
    vecs.push_back(v);
  endfunction

  task automatic drive_idle();
    bus.flush_start   = 1'b0;
    bus.host_set      = 1'b0;
    bus.host_saddr    = '0;
    bus.wr_ack        = 1'b0;
    bus.wr_done       = 1'b0;
    bus.wr_err        = 1'b0;
    bus.dirty_sectors = bm;
    bus.all_clean     = (bm == 64'd0);
  endtask

  task automatic compare_q(input string name);
    check({name, ".count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s.wr_saddr[%0d]", name, i), 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  // Runs one flush against the bench bitmap with a writer that acks at once and
  // finishes the cycle after; n_err failures first, optional host rewrite during
  // the first write's WAIT. result: 0 done, 1 error, 2 timeout.
  task automatic run_flush(input logic [63:0] init_bm, input int n_err,
                           input int host_sec, output int result);
    int   errs_left;
    logic pend;
    int   wr_no;
    logic den, dd;
    int   dsa;
    errs_left = n_err;
    pend      = 1'b0;
    wr_no     = 0;
    bm        = init_bm;
    result    = 2;
    busy_at_end = 1'b1;
    got_q.delete();
    @(negedge clk);
    drive_idle();
    bus.flush_start = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      drive_idle();
      bus.wr_ack     = bus.wr_req;
      bus.wr_done    = pend;
      bus.wr_err     = pend && (errs_left > 0);
      bus.host_set   = pend && (host_sec >= 0) && (wr_no == 1);
      bus.host_saddr = (host_sec >= 0) ? SADDR_W'(host_sec) : '0;
      #1;
      if (pend) begin
        pend = 1'b0;
        if (errs_left > 0) errs_left--;
      end
      if (bus.wr_req) begin
        got_q.push_back(bus.wr_saddr);
        pend = 1'b1;
        wr_no++;
      end
      den = bus.ds_en;
      dsa = int'(bus.ds_saddr);
      dd  = bus.ds_d;
      if (bus.flush_done || bus.flush_error) begin
        result      = bus.flush_done ? 0 : 1;
        busy_at_end = bus.busy;
        break;
      end
      @(posedge clk);
      if (den) bm[dsa] = dd;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int res;
    bm = 64'd0;
    drive_idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    //   fs hs ha  ack done err dirty                   req wsa den dsa dd busy fd fe
    add(0, 0, 0,  0, 0, 0, 64'h0,                    0, 0,  0, 0,  0, 0, 0, 0);
    add(1, 0, 0,  0, 0, 0, 64'h0,                    0, 0,  0, 0,  0, 0, 0, 0);
    add(0, 0, 0,  0, 0, 0, 64'h0,                    0, 0,  0, 0,  0, 1, 0, 0);
    add(0, 0, 0,  0, 0, 0, 64'h0,                    0, 0,  0, 0,  0, 0, 1, 0);
    add(0, 0, 0,  0, 0, 0, 64'h0,                    0, 0,  0, 0,  0, 0, 0, 0);
    add(1, 0, 0,  0, 0, 0, 64'h8000_0000_0000_0009,  0, 0,  0, 0,  0, 0, 0, 0);
    add(0, 0, 0,  0, 0, 0, 64'h8000_0000_0000_0009,  0, 0,  0, 0,  0, 1, 0, 0);
    add(0, 0, 0,  1, 0, 0, 64'h8000_0000_0000_0009,  1, 0,  0, 0,  0, 1, 0, 0);
    add(0, 0, 0,  0, 1, 0, 64'h8000_0000_0000_0009,  0, 0,  0, 0,  0, 1, 0, 0);
    add(0, 0, 0,  0, 0, 0, 64'h8000_0000_0000_0009,  0, 0,  1, 0,  0, 1, 0, 0);
    add(0, 0, 0,  0, 0, 0, 64'h8000_0000_0000_0008,  0, 0,  0, 0,  0, 1, 0, 0);
    add(0, 0, 0,  1, 0, 0, 64'h8000_0000_0000_0008,  1, 3,  0, 0,  0, 1, 0, 0);
    add(0, 0, 0,  0, 1, 0, 64'h8000_0000_0000_0008,  0, 3,  0, 0,  0, 1, 0, 0);
    add(0, 0, 0,  0, 0, 0, 64'h8000_0000_0000_0008,  0, 3,  1, 3,  0, 1, 0, 0);
    add(0, 0, 0,  0, 0, 0, 64'h8000_0000_0000_0000,  0, 3,  0, 0,  0, 1, 0, 0);
    add(0, 0, 0,  1, 0, 0, 64'h8000_0000_0000_0000,  1, 63, 0, 0,  0, 1, 0, 0);
    add(1, 0, 0,  0, 1, 0, 64'h8000_0000_0000_0000,  0, 63, 0, 0,  0, 1, 0, 0);
    add(0, 0, 0,  0, 0, 0, 64'h8000_0000_0000_0000,  0, 63, 1, 63, 0, 1, 0, 0);
    add(0, 0, 0,  0, 0, 0, 64'h0,                    0, 63, 0, 0,  0, 1, 0, 0);
    add(0, 0, 0,  0, 0, 0, 64'h0,                    0, 63, 0, 0,  0, 0, 1, 0);
    add(1, 0, 0,  0, 0, 0, 64'h20,                   0, 63, 0, 0,  0, 0, 0, 0);
    add(0, 0, 0,  0, 0, 0, 64'h20,                   0, 63, 0, 0,  0, 1, 0, 0);
    add(0, 0, 0,  0, 0, 0, 64'h20,                   1, 5,  0, 0,  0, 1, 0, 0);
    add(0, 0, 0,  1, 0, 0, 64'h20,                   1, 5,  0, 0,  0, 1, 0, 0);
    add(0, 0, 0,  0, 1, 0, 64'h20,                   0, 5,  0, 0,  0, 1, 0, 0);
    add(0, 1, 9,  0, 0, 0, 64'h20,                   0, 5,  1, 9,  1, 1, 0, 0);
    add(0, 0, 0,  0, 0, 0, 64'h220,                  0, 5,  1, 5,  0, 1, 0, 0);
    add(0, 0, 0,  0, 0, 0, 64'h200,                  0, 5,  0, 0,  0, 1, 0, 0);
    add(0, 0, 0,  1, 1, 0, 64'h200,                  1, 9,  0, 0,  0, 1, 0, 0);
    add(0, 0, 0,  0, 0, 0, 64'h200,                  0, 9,  1, 9,  0, 1, 0, 0);
    add(0, 0, 0,  0, 0, 0, 64'h0,                    0, 9,  0, 0,  0, 1, 0, 0);
    add(0, 0, 0,  0, 0, 0, 64'h0,                    0, 9,  0, 0,  0, 0, 1, 0);
    add(0, 1, 17, 0, 0, 0, 64'h0,                    0, 9,  1, 17, 1, 0, 0, 0);
    add(0, 0, 0,  0, 0, 0, 64'h20000,                0, 9,  0, 0,  0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      bus.flush_start   = vecs[i].fs;
      bus.host_set      = vecs[i].hs;
      bus.host_saddr    = SADDR_W'(vecs[i].ha);
      bus.wr_ack        = vecs[i].ack;
      bus.wr_done       = vecs[i].done;
      bus.wr_err        = vecs[i].err;
      bus.dirty_sectors = vecs[i].dirty;
      bus.all_clean     = (vecs[i].dirty == 64'd0);
      #1;
      check($sformatf("v%0d.wr_req", i),      64'(bus.wr_req),      64'(vecs[i].req));
      check($sformatf("v%0d.wr_saddr", i),    64'(bus.wr_saddr),    64'(vecs[i].wsa));
      check($sformatf("v%0d.ds_en", i),       64'(bus.ds_en),       64'(vecs[i].den));
      check($sformatf("v%0d.ds_saddr", i),    64'(bus.ds_saddr),    64'(vecs[i].dsa));
      check($sformatf("v%0d.ds_d", i),        64'(bus.ds_d),        64'(vecs[i].dd));
      check($sformatf("v%0d.busy", i),        64'(bus.busy),        64'(vecs[i].busy));
      check($sformatf("v%0d.flush_done", i),  64'(bus.flush_done),  64'(vecs[i].fdone));
      check($sformatf("v%0d.flush_error", i), 64'(bus.flush_error), 64'(vecs[i].ferr));
    end

    // Leave the scan pointer at 62, then expect 62 before 1.
    run_flush(64'h1 << 61, 0, -1, res);
    check("prep61.result", 64'(res), 64'd0);
    exp_q = '{6'd61};
    compare_q("prep61");
    run_flush((64'h1 << 62) | 64'h2, 0, -1, res);
    check("wrap.result", 64'(res), 64'd0);
    exp_q = '{6'd62, 6'd1};
    compare_q("wrap");
    check("wrap.bitmap", bm, 64'd0);

    // Host rewrites sector 5 while its write is outstanding.
    run_flush(64'h20, 0, 5, res);
    check("redirty.result", 64'(res), 64'd0);
    exp_q = '{6'd5, 6'd5};
    compare_q("redirty");
    check("redirty.bitmap", bm, 64'd0);

    // Exactly MAX_RETRY failures still succeed.
    run_flush(64'h80, 3, -1, res);
    check("retry3.result", 64'(res), 64'd0);
    exp_q = '{6'd7, 6'd7, 6'd7, 6'd7};
    compare_q("retry3");
    check("retry3.bitmap", bm, 64'd0);

    // One failure more aborts and leaves the bit dirty.
    run_flush(64'h80, 4, -1, res);
    check("abort.result", 64'(res), 64'd1);
    exp_q = '{6'd7, 6'd7, 6'd7, 6'd7};
    compare_q("abort");
    check("abort.bitmap", bm, 64'h80);
    check("abort.busy", 64'(busy_at_end), 64'd0);

    // Reset while waiting on the writer.
    @(negedge clk);
    drive_idle();
    bus.flush_start = 1'b1;
    @(negedge clk);
    bus.flush_start = 1'b0;
    #1;
    check("rst.pick_busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    bus.wr_ack = 1'b1;
    #1;
    check("rst.issue_req", 64'(bus.wr_req), 64'd1);
    check("rst.issue_saddr", 64'(bus.wr_saddr), 64'd7);
    @(negedge clk);
    bus.wr_ack = 1'b0;
    reset      = 1'b1;
    #1;
    check("rst.wait_busy", 64'(bus.busy), 64'd1);
    check("rst.wait_req", 64'(bus.wr_req), 64'd0);
    @(negedge clk);
    #1;
    check("rst.after_req", 64'(bus.wr_req), 64'd0);
    check("rst.after_busy", 64'(bus.busy), 64'd0);
    check("rst.after_saddr", 64'(bus.wr_saddr), 64'd0);
    check("rst.after_ds_en", 64'(bus.ds_en), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("rst.idle_req", 64'(bus.wr_req), 64'd0);
    check("rst.idle_busy", 64'(bus.busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
